cpu_writeback: RTL and testbench

//  W-stage of the MCS8 pipeline: M/W pipeline register plus 8x8 register bank write port.

---
 rtl/cpu_writeback_if.sv | 57 +++++
 rtl/cpu_writeback.sv | 141 ++++++++++++++
 tb/tb_cpu_writeback.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_writeback_if.sv
// W-stage bus bundle: M-stage inputs, W-stage register copies, and the two decode read ports.
// Latency: none; wires only.
// Backpressure: W_STALL_I holds W and W_BUBBLE_I inserts a bubble, both driven by pipeline control.
interface cpu_writeback_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              W_STALL_I;
    logic              W_BUBBLE_I;
    logic              M_VALID_I;
    logic [ADDR_W-1:0] M_DST_I;
    logic              M_DSTR_CS_I;
    logic              M_DSTR_CS_C_I;
    logic              M_DSTR_CS_S_I;
    logic              M_DSTR_CS_E_I;
    logic              M_DSTR_CS_M_I;
    logic [DATA_W-1:0] M_VAL_C_I;
    logic [DATA_W-1:0] M_VAL_S_I;
    logic [DATA_W-1:0] M_VAL_E_I;
    logic [DATA_W-1:0] M_VAL_M_I;
    logic [ADDR_W-1:0] RD_A_SRC_I;
    logic [ADDR_W-1:0] RD_B_SRC_I;

    logic              W_VALID_O;
    logic [ADDR_W-1:0] W_DST_O;
    logic              W_DSTR_CS_O;
    logic              W_DSTR_CS_C_O;
    logic              W_DSTR_CS_S_O;
    logic              W_DSTR_CS_E_O;
    logic              W_DSTR_CS_M_O;
    logic [DATA_W-1:0] W_VAL_C_O;
    logic [DATA_W-1:0] W_VAL_S_O;
    logic [DATA_W-1:0] W_VAL_E_O;
    logic [DATA_W-1:0] W_VAL_M_O;
    logic [DATA_W-1:0] RD_A_O;
    logic [DATA_W-1:0] RD_B_O;

    // Write-back stage side
    modport slave (
        input  W_STALL_I, W_BUBBLE_I, M_VALID_I, M_DST_I, M_DSTR_CS_I,
               M_DSTR_CS_C_I, M_DSTR_CS_S_I, M_DSTR_CS_E_I, M_DSTR_CS_M_I,
               M_VAL_C_I, M_VAL_S_I, M_VAL_E_I, M_VAL_M_I, RD_A_SRC_I, RD_B_SRC_I,
        output W_VALID_O, W_DST_O, W_DSTR_CS_O,
               W_DSTR_CS_C_O, W_DSTR_CS_S_O, W_DSTR_CS_E_O, W_DSTR_CS_M_O,
               W_VAL_C_O, W_VAL_S_O, W_VAL_E_O, W_VAL_M_O, RD_A_O, RD_B_O
    );

    // Pipeline control / M-stage / decode side
    modport master (
        output W_STALL_I, W_BUBBLE_I, M_VALID_I, M_DST_I, M_DSTR_CS_I,
               M_DSTR_CS_C_I, M_DSTR_CS_S_I, M_DSTR_CS_E_I, M_DSTR_CS_M_I,
               M_VAL_C_I, M_VAL_S_I, M_VAL_E_I, M_VAL_M_I, RD_A_SRC_I, RD_B_SRC_I,
        input  W_VALID_O, W_DST_O, W_DSTR_CS_O,
               W_DSTR_CS_C_O, W_DSTR_CS_S_O, W_DSTR_CS_E_O, W_DSTR_CS_M_O,
               W_VAL_C_O, W_VAL_S_O, W_VAL_E_O, W_VAL_M_O, RD_A_O, RD_B_O
    );
endinterface

// File: rtl/cpu_writeback.sv
// MCS8 W stage: M/W pipeline register, register bank write port, two combinational read ports.
// Latency: M_* -> W_* one cycle; commit to the bank on the edge the entry leaves W.
// Backpressure: W_STALL_I holds W (no commit); W_BUBBLE_I loads an invalid entry. Optional
// write-through read bypass enabled by defining CPU_WB_BYPASS_EN.
module cpu_writeback #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    cpu_writeback_if.slave  wb
);

    localparam logic [ADDR_W:0] NREG_LIM = (ADDR_W + 1)'(NREG);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dst;
        logic              cs;
        logic              cs_c;
        logic              cs_s;
        logic              cs_e;
        logic              cs_m;
        logic [DATA_W-1:0] val_c;
        logic [DATA_W-1:0] val_s;
        logic [DATA_W-1:0] val_e;
        logic [DATA_W-1:0] val_m;
    } w_ent_t;

    w_ent_t            m_ent;
    w_ent_t            w_d;
    w_ent_t            w_q;
    logic [DATA_W-1:0] wd;
    logic              commit;
    logic              dst_ok;
    logic [DATA_W-1:0] bank_d [NREG];
    logic [DATA_W-1:0] bank_q [NREG];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Gather the M-stage entry into one record
    always_comb begin
        m_ent       = '0;
        m_ent.valid = wb.M_VALID_I;
        m_ent.dst   = wb.M_DST_I;
        m_ent.cs    = wb.M_DSTR_CS_I;
        m_ent.cs_c  = wb.M_DSTR_CS_C_I;
        m_ent.cs_s  = wb.M_DSTR_CS_S_I;
        m_ent.cs_e  = wb.M_DSTR_CS_E_I;
        m_ent.cs_m  = wb.M_DSTR_CS_M_I;
        m_ent.val_c = wb.M_VAL_C_I;
        m_ent.val_s = wb.M_VAL_S_I;
        m_ent.val_e = wb.M_VAL_E_I;
        m_ent.val_m = wb.M_VAL_M_I;
    end

    // W next state: bubble beats stall beats load; bubble keeps the data fields
    always_comb begin
        w_d = w_q;
        if (wb.W_BUBBLE_I) begin
            w_d.valid = 1'b0;
            w_d.cs    = 1'b0;
            w_d.cs_c  = 1'b0;
            w_d.cs_s  = 1'b0;
            w_d.cs_e  = 1'b0;
            w_d.cs_m  = 1'b0;
        end else if (!wb.W_STALL_I) begin
            w_d = m_ent;
        end
    end

    // W pipeline register
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

    // Result select, same AND-OR combine the forwarding unit uses; commit when the entry leaves W
    always_comb begin
        wd = ({DATA_W{w_q.cs_c}} & w_q.val_c)
           | ({DATA_W{w_q.cs_s}} & w_q.val_s)
           | ({DATA_W{w_q.cs_e}} & w_q.val_e)
           | ({DATA_W{w_q.cs_m}} & w_q.val_m);
        commit = w_q.valid & w_q.cs & ~wb.W_STALL_I & ~RST_I;
        dst_ok = ({1'b0, w_q.dst} < NREG_LIM);
    end

    // Bank next state: single write port
    always_comb begin
        bank_d = bank_q;
        if (commit && dst_ok) begin
            bank_d[w_q.dst] = wd;
        end
    end

    // Register bank storage
    always_ff @(posedge CLK_I) begin
        for (int i = 0; i < NREG; i++) begin
            bank_q[i] <= RST_I ? '0 : bank_d[i];
        end
    end

    // Read ports; out-of-range indices read zero
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if ({1'b0, wb.RD_A_SRC_I} < NREG_LIM) begin
            rd_a = bank_q[wb.RD_A_SRC_I];
        end
        if ({1'b0, wb.RD_B_SRC_I} < NREG_LIM) begin
            rd_b = bank_q[wb.RD_B_SRC_I];
        end
`ifdef CPU_WB_BYPASS_EN
        if (commit && dst_ok && (wb.RD_A_SRC_I == w_q.dst)) begin
            rd_a = wd;
        end
        if (commit && dst_ok && (wb.RD_B_SRC_I == w_q.dst)) begin
            rd_b = wd;
        end
`endif
    end

    assign wb.W_VALID_O     = w_q.valid;
    assign wb.W_DST_O       = w_q.dst;
    assign wb.W_DSTR_CS_O   = w_q.cs;
    assign wb.W_DSTR_CS_C_O = w_q.cs_c;
    assign wb.W_DSTR_CS_S_O = w_q.cs_s;
    assign wb.W_DSTR_CS_E_O = w_q.cs_e;
    assign wb.W_DSTR_CS_M_O = w_q.cs_m;
    assign wb.W_VAL_C_O     = w_q.val_c;
    assign wb.W_VAL_S_O     = w_q.val_s;
    assign wb.W_VAL_E_O     = w_q.val_e;
    assign wb.W_VAL_M_O     = w_q.val_m;
    assign wb.RD_A_O        = rd_a;
    assign wb.RD_B_O        = rd_b;

endmodule

// File: tb/tb_cpu_writeback.sv
// Bench for cpu_writeback: directed table of W-stage scenarios, then random traffic vs a model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: stall/bubble/reset are driven directly by the bench.
module tb_cpu_writeback;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;

    localparam logic [3:0] SC = 4'b1000;
    localparam logic [3:0] SS = 4'b0100;
    localparam logic [3:0] SE = 4'b0010;
    localparam logic [3:0] SM = 4'b0001;

    // sel bit 3..0 = C,S,E,M ; v[3..0] = C,S,E,M values
    typedef struct packed {
        logic             valid;
        logic [2:0]       dst;
        logic             cs;
        logic [3:0]       sel;
        logic [3:0][7:0]  v;
    } ent_t;

    typedef struct {
        logic       rst, stall, bub;
        ent_t       m;
        logic [2:0] ra, rb;
        logic       ew;
        logic [7:0] ea, eab, eb, ebb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    cpu_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    cpu_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: the entry in W and the architectural register contents
    ent_t       mw;
    logic [7:0] mregs [NREG];
    logic       cur_rst, cur_stall, cur_bub;
    ent_t       cur_m;

    vec_t tbl[$];

    function automatic ent_t mk_ent(input logic va, input logic [2:0] dst, input logic cs,
                                    input logic [3:0] sel, input logic [7:0] vc, vs, ve, vm);
        ent_t e;
        e.valid = va; e.dst = dst; e.cs = cs; e.sel = sel;
        e.v = {vc, vs, ve, vm};
        return e;
    endfunction

    function automatic vec_t mk(input logic r, st, bu, va, input logic [2:0] dst, input logic cs,
                                input logic [3:0] sel, input logic [7:0] vc, vs, ve, vm,
                                input logic [2:0] ra, rb, input logic ew,
                                input logic [7:0] ea, eab, eb, ebb);
        vec_t t;
        t.rst = r; t.stall = st; t.bub = bu;
        t.m = mk_ent(va, dst, cs, sel, vc, vs, ve, vm);
        t.ra = ra; t.rb = rb; t.ew = ew;
        t.ea = ea; t.eab = eab; t.eb = eb; t.ebb = ebb;
        return t;
    endfunction

    function automatic vec_t idle(input logic [2:0] ra, rb, input logic ew,
                                  input logic [7:0] ea, eab, eb, ebb);
        return mk(0, 0, 0, 0, 3'd0, 0, 4'b0, 8'h00, 8'h00, 8'h00, 8'h00, ra, rb, ew, ea, eab, eb, ebb);
    endfunction

    // Committed value: OR of every selected lane
    function automatic logic [7:0] m_wd(input ent_t e);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 4; i++) if (e.sel[i]) r = r | e.v[i];
        return r;
    endfunction

    function automatic logic m_commit();
        return mw.valid && mw.cs && !cur_stall && !cur_rst;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] src);
        logic [7:0] r = (int'(src) < NREG) ? mregs[src] : 8'h00;
`ifdef CPU_WB_BYPASS_EN
        if (m_commit() && src == mw.dst) r = m_wd(mw);
`endif
        return r;
    endfunction

    task automatic model_edge();
        if (cur_rst) begin
            mw = '0;
            for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
        end else begin
            if (m_commit() && int'(mw.dst) < NREG) mregs[mw.dst] = m_wd(mw);
            if (cur_bub) begin
                mw.valid = 1'b0; mw.cs = 1'b0; mw.sel = 4'b0;
            end else if (!cur_stall) begin
                mw = cur_m;
            end
        end
    endtask

    task automatic drive(input logic r, st, bu, input ent_t e, input logic [2:0] ra, rb);
        rst = r; cur_rst = r; cur_stall = st; cur_bub = bu; cur_m = e;
        bus.W_STALL_I     = st;
        bus.W_BUBBLE_I    = bu;
        bus.M_VALID_I     = e.valid;
        bus.M_DST_I       = e.dst;
        bus.M_DSTR_CS_I   = e.cs;
        bus.M_DSTR_CS_C_I = e.sel[3];
        bus.M_DSTR_CS_S_I = e.sel[2];
        bus.M_DSTR_CS_E_I = e.sel[1];
        bus.M_DSTR_CS_M_I = e.sel[0];
        bus.M_VAL_C_I     = e.v[3];
        bus.M_VAL_S_I     = e.v[2];
        bus.M_VAL_E_I     = e.v[1];
        bus.M_VAL_M_I     = e.v[0];
        bus.RD_A_SRC_I    = ra;
        bus.RD_B_SRC_I    = rb;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input int cyc);
        string p;
        p = $sformatf("rnd%0d", cyc);
        chk({p, "_w_valid"}, 32'(bus.W_VALID_O),     32'(mw.valid));
        chk({p, "_w_dst"},   32'(bus.W_DST_O),       32'(mw.dst));
        chk({p, "_w_cs"},    32'(bus.W_DSTR_CS_O),   32'(mw.cs));
        chk({p, "_w_sel"},   32'({bus.W_DSTR_CS_C_O, bus.W_DSTR_CS_S_O,
                                  bus.W_DSTR_CS_E_O, bus.W_DSTR_CS_M_O}), 32'(mw.sel));
        chk({p, "_w_vals"},  {bus.W_VAL_C_O, bus.W_VAL_S_O, bus.W_VAL_E_O, bus.W_VAL_M_O}, mw.v);
        chk({p, "_rd_a"},    32'(bus.RD_A_O), 32'(m_read(bus.RD_A_SRC_I)));
        chk({p, "_rd_b"},    32'(bus.RD_B_O), 32'(m_read(bus.RD_B_SRC_I)));
    endtask

    initial begin
        // rst, stall, bub, valid, dst, cs, sel, vC, vS, vE, vM, ra, rb, ew, ea, ea_byp, eb, eb_byp
        tbl.push_back(mk(0,0,0,1,3'd3,1,SC,8'h5A,8'hEE,8'hEE,8'hEE,3'd3,3'd0,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(idle(3'd3,3'd3,1,8'h00,8'h5A,8'h00,8'h5A));
        tbl.push_back(idle(3'd3,3'd3,0,8'h5A,8'h5A,8'h5A,8'h5A));
        tbl.push_back(mk(0,0,0,1,3'd7,1,SM,8'hEE,8'hEE,8'hEE,8'hC3,3'd7,3'd7,0,8'h00,8'h00,8'h00,8'h00));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,0,1,3'd6,1,SC,8'h99,8'hEE,8'hEE,8'hEE,3'd7,3'd6,1,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(idle(3'd7,3'd7,1,8'h00,8'hC3,8'h00,8'hC3));
        tbl.push_back(idle(3'd7,3'd6,0,8'hC3,8'hC3,8'h00,8'h00));
        tbl.push_back(idle(3'd7,3'd7,0,8'hC3,8'hC3,8'hC3,8'hC3));
        tbl.push_back(mk(0,0,1,1,3'd2,1,SC,8'h11,8'hEE,8'hEE,8'hEE,3'd2,3'd2,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(idle(3'd2,3'd2,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(mk(0,0,0,1,3'd4,1,SC,8'h44,8'hEE,8'hEE,8'hEE,3'd4,3'd4,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(mk(0,1,1,0,3'd0,0,4'b0,8'h00,8'h00,8'h00,8'h00,3'd4,3'd4,1,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(idle(3'd4,3'd4,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(mk(0,0,0,1,3'd4,1,SC,8'h45,8'hEE,8'hEE,8'hEE,3'd4,3'd4,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(mk(0,0,1,1,3'd0,1,SC,8'h77,8'hEE,8'hEE,8'hEE,3'd4,3'd0,1,8'h00,8'h45,8'h00,8'h00));
        tbl.push_back(idle(3'd4,3'd0,0,8'h45,8'h45,8'h00,8'h00));
        tbl.push_back(mk(0,0,0,1,3'd5,1,SE,8'hEE,8'hEE,8'hA7,8'hEE,3'd5,3'd5,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(idle(3'd5,3'd5,1,8'h00,8'hA7,8'h00,8'hA7));
        tbl.push_back(idle(3'd5,3'd5,0,8'hA7,8'hA7,8'hA7,8'hA7));
        tbl.push_back(mk(0,0,0,1,3'd1,1,SC,8'hFF,8'hEE,8'hEE,8'hEE,3'd1,3'd1,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(mk(1,0,0,0,3'd0,0,4'b0,8'h00,8'h00,8'h00,8'h00,3'd1,3'd5,1,8'h00,8'h00,8'hA7,8'hA7));
        tbl.push_back(idle(3'd1,3'd5,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(mk(0,0,0,1,3'd6,0,SC,8'h12,8'hEE,8'hEE,8'hEE,3'd6,3'd6,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(idle(3'd6,3'd6,1,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(idle(3'd6,3'd6,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(mk(0,0,0,1,3'd6,1,SC|SS,8'h30,8'h05,8'hEE,8'hEE,3'd6,3'd6,0,8'h00,8'h00,8'h00,8'h00));
        tbl.push_back(idle(3'd6,3'd3,1,8'h00,8'h35,8'h00,8'h00));
        tbl.push_back(idle(3'd6,3'd6,0,8'h35,8'h35,8'h35,8'h35));
        tbl.push_back(mk(0,0,0,1,3'd6,1,4'b0,8'hFF,8'hFF,8'hFF,8'hFF,3'd6,3'd6,0,8'h35,8'h35,8'h35,8'h35));
        tbl.push_back(idle(3'd6,3'd6,1,8'h35,8'h00,8'h35,8'h00));
        tbl.push_back(idle(3'd6,3'd6,0,8'h00,8'h00,8'h00,8'h00));

        mw = '0;
        for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;

        // Two reset cycles, then every index must read zero on both ports
        drive(1, 0, 0, '0, 3'd0, 3'd0);
        tick();
        tick();
        for (int i = 0; i < NREG; i++) begin
            drive(0, 0, 0, '0, 3'(i), 3'(NREG - 1 - i));
            #4;
            chk($sformatf("reset_w_valid%0d", i), 32'(bus.W_VALID_O), 32'd0);
            chk($sformatf("reset_rd_a%0d", i), 32'(bus.RD_A_O), 32'd0);
            chk($sformatf("reset_rd_b%0d", i), 32'(bus.RD_B_O), 32'd0);
            tick();
        end

        // Directed scenarios
        foreach (tbl[k]) begin
            logic [7:0] xa, xb;
            drive(tbl[k].rst, tbl[k].stall, tbl[k].bub, tbl[k].m, tbl[k].ra, tbl[k].rb);
            #4;
`ifdef CPU_WB_BYPASS_EN
            xa = tbl[k].eab; xb = tbl[k].ebb;
`else
            xa = tbl[k].ea;  xb = tbl[k].eb;
`endif
            chk($sformatf("tbl%0d_w_valid", k), 32'(bus.W_VALID_O), 32'(tbl[k].ew));
            chk($sformatf("tbl%0d_rd_a", k), 32'(bus.RD_A_O), 32'(xa));
            chk($sformatf("tbl%0d_rd_b", k), 32'(bus.RD_B_O), 32'(xb));
            tick();
        end

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            ent_t e;
            int   r;
            e.valid = ($urandom_range(0, 3) != 0);
            e.dst   = 3'($urandom_range(0, 7));
            e.cs    = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 9));
            if (r < 8)       e.sel = 4'(1 << (r % 4));
            else if (r == 8) e.sel = 4'b0;
            else             e.sel = 4'($urandom_range(0, 15));
            e.v = $urandom;
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), e,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            #4;
            chk_model(c);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
